// File: rtl/toggle_sequencer.sv
// toggle_sequencer: command-driven square-wave sequencer.
// Each accepted command carries a half-period P and an inversion count N.
// One pending slot lets a second command start on the exact completion edge
// of the active one, so back-to-back bursts have no idle cycle.
module toggle_sequencer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned N_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic [N_W-1:0]   cmd_count,
    input  logic             abort,
    output logic             toggle,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_q,   per_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_W-1:0]   rem_q,   rem_d;
    logic             pend_q,  pend_d;
    logic [CNT_W-1:0] pper_q,  pper_d;
    logic [N_W-1:0]   pcnt_q,  pcnt_d;
    logic             tog_q,   tog_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic xfer;
    logic xfer_ok;
    logic xfer_bad;
    logic running;
    logic wrap;
    logic invert;
    logic complete;

    // Handshake: the slot is free whenever no command is pending and no flush is requested.
    assign cmd_ready = rst && !abort && !pend_q;

    assign xfer     = cmd_valid && cmd_ready;
    assign xfer_ok  = xfer && (cmd_period != '0);
    assign xfer_bad = xfer && (cmd_period == '0);
    assign running  = (state_q == RUN);
    assign wrap     = (cnt_q == per_q - CNT_W'(1));
    assign invert   = running && (rem_q != '0) && wrap;
    // A zero-count command completes one cycle after activation without inverting.
    assign complete = running && ((rem_q == '0) || ((rem_q == N_W'(1)) && wrap));

    assign toggle = tog_q;
    assign busy   = running;
    assign done   = done_q;
    assign err    = err_q;

    // Next-state: counting, inversion, completion hand-over, slot fill and flush.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        pend_d  = pend_q;
        pper_d  = pper_q;
        pcnt_d  = pcnt_q;
        tog_d   = tog_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            tog_d   = 1'b0;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            err_d = xfer_bad;
            if (running) begin
                if (invert) begin
                    tog_d = ~tog_q;
                    cnt_d = '0;
                    rem_d = rem_q - N_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (complete) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (pend_q) begin
                        // Pending command takes over on the completion edge itself.
                        per_d   = pper_q;
                        rem_d   = pcnt_q;
                        pend_d  = 1'b0;
                        state_d = RUN;
                    end else if (xfer_ok) begin
                        per_d   = cmd_period;
                        rem_d   = cmd_count;
                        state_d = RUN;
                    end else begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end
                end else if (xfer_ok) begin
                    pend_d = 1'b1;
                    pper_d = cmd_period;
                    pcnt_d = cmd_count;
                end
            end else if (xfer_ok) begin
                per_d   = cmd_period;
                rem_d   = cmd_count;
                cnt_d   = '0;
                state_d = RUN;
            end
        end
    end

    // State and registered outputs, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            pper_q  <= '0;
            pcnt_q  <= '0;
            tog_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            pper_q  <= pper_d;
            pcnt_q  <= pcnt_d;
            tog_q   <= tog_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_toggle_sequencer.sv
// Directed testbench for toggle_sequencer with hand-computed expectations.
module tb_toggle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_period;
    logic [7:0]  cmd_count;
    logic        abort;
    logic        toggle;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    toggle_sequencer #(.CNT_W(16), .N_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_period (cmd_period),
        .cmd_count  (cmd_count),
        .abort      (abort),
        .toggle     (toggle),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [15:0] p, input logic [7:0] n);
        cmd_valid  = 1'b1;
        cmd_period = p;
        cmd_count  = n;
    endtask

    initial begin
        int unsigned inv;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_period = '0;
        cmd_count  = '0;
        abort      = 1'b0;
        #2;
        check("rst_toggle", toggle, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", cmd_ready, 0);
        step();
        step();
        rst = 1'b1;
        #0;
        check("ready_after_rst", cmd_ready, 1);

        // 1: P=3 N=4, inversions at +3,+6,+9,+12
        drive_cmd(16'd3, 8'd4);
        step();
        cmd_valid = 1'b0;
        check("t1_busy0", busy, 1);
        check("t1_tog0", toggle, 0);
        for (int k = 1; k <= 13; k++) begin
            step();
            inv = (k >= 3) + (k >= 6) + (k >= 9) + (k >= 12);
            check($sformatf("t1_tog%0d", k), toggle, inv % 2);
            check($sformatf("t1_busy%0d", k), busy, (k < 12) ? 1 : 0);
            check($sformatf("t1_done%0d", k), done, (k == 12) ? 1 : 0);
        end

        // 2: P=2 N=2 then P=5 N=1 queued; inversions at +2,+4,+9
        drive_cmd(16'd2, 8'd2);
        step();
        drive_cmd(16'd5, 8'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            cmd_valid = 1'b0;
            inv = (k >= 2) + (k >= 4) + (k >= 9);
            check($sformatf("t2_tog%0d", k), toggle, inv % 2);
            check($sformatf("t2_busy%0d", k), busy, (k < 9) ? 1 : 0);
            check($sformatf("t2_done%0d", k), done, (k == 4 || k == 9) ? 1 : 0);
            check($sformatf("t2_ready%0d", k), cmd_ready, (k >= 1 && k <= 3) ? 0 : 1);
        end

        // 3: P=0 is dropped with an err pulse; toggle stays 1
        drive_cmd(16'd0, 8'd7);
        step();
        cmd_valid = 1'b0;
        check("t3_err", err, 1);
        check("t3_busy", busy, 0);
        check("t3_tog", toggle, 1);
        check("t3_done", done, 0);
        step();
        check("t3_err_end", err, 0);
        check("t3_busy_end", busy, 0);
        check("t3_done_end", done, 0);

        // 4: N=0 in IDLE: one busy cycle, then done, no inversion
        drive_cmd(16'd4, 8'd0);
        step();
        cmd_valid = 1'b0;
        check("t4_busy", busy, 1);
        check("t4_done0", done, 0);
        step();
        check("t4_busy_end", busy, 0);
        check("t4_done", done, 1);
        check("t4_tog", toggle, 1);
        step();
        check("t4_done_end", done, 0);

        // 5: P=10 N=5 from toggle=1, slot filled, abort on edge +23
        drive_cmd(16'd10, 8'd5);
        step();
        drive_cmd(16'd3, 8'd2);
        for (int k = 1; k <= 22; k++) begin
            step();
            cmd_valid = 1'b0;
            if (k == 10 || k == 20 || k == 22) begin
                inv = (k >= 10) + (k >= 20);
                check($sformatf("t5_tog%0d", k), toggle, (inv % 2 == 0) ? 1 : 0);
                check($sformatf("t5_busy%0d", k), busy, 1);
            end
        end
        check("t5_ready_full", cmd_ready, 0);
        abort = 1'b1;
        #0;
        check("t5_ready_abort", cmd_ready, 0);
        step();
        abort = 1'b0;
        check("t5_tog_abort", toggle, 0);
        check("t5_busy_abort", busy, 0);
        check("t5_done_abort", done, 0);
        #0;
        check("t5_ready_after", cmd_ready, 1);
        drive_cmd(16'd1, 8'd2);
        step();
        cmd_valid = 1'b0;
        check("t5_new_busy", busy, 1);
        step();
        check("t5_new_tog1", toggle, 1);
        step();
        check("t5_new_tog2", toggle, 0);
        check("t5_new_done", done, 1);
        check("t5_new_busy_end", busy, 0);
        step();
        check("t5_no_pending", busy, 0);

        // 6: async reset mid-run
        drive_cmd(16'd5, 8'd3);
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        check("t6_tog_pre", toggle, 1);
        check("t6_busy_pre", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_tog_rst", toggle, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_ready_rst", cmd_ready, 0);
        step();
        check("t6_busy_hold", busy, 0);
        check("t6_ready_hold", cmd_ready, 0);
        rst = 1'b1;
        drive_cmd(16'd2, 8'd1);
        #0;
        check("t6_ready_rel", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("t6_busy_new", busy, 1);
        step();
        check("t6_tog_mid", toggle, 0);
        step();
        check("t6_tog_new", toggle, 1);
        check("t6_done_new", done, 1);

        // 7: P=0 command accepted on a completion edge: done and err together
        drive_cmd(16'd1, 8'd1);
        step();
        drive_cmd(16'd0, 8'd7);
        #0;
        check("t7_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("t7_done", done, 1);
        check("t7_err", err, 1);
        check("t7_tog", toggle, 0);
        check("t7_busy", busy, 0);
        step();
        check("t7_done_end", done, 0);
        check("t7_err_end", err, 0);
        check("t7_busy_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
